// File: rtl/rtc_bcd_counter.sv
// rtc_bcd_counter: BCD time-of-day / countdown counter with built-in tick divider.
// Counts hh:mm:ss up or down in 12- or 24-hour range, with validated parallel load
// and a sticky countdown-done flag. Define RTC_ALARM_EN to build the hh:mm alarm.
module rtc_bcd_counter #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1,
    parameter int HOUR_MODE = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       dir,
    input  logic       load,
    input  logic [7:0] ld_hr,
    input  logic [7:0] ld_min,
    input  logic [7:0] ld_sec,
    output logic [7:0] hr,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       tick,
    output logic       done,
    output logic       load_err,
    input  logic       alm_arm,
    input  logic       alm_clr,
    input  logic [7:0] alm_hr,
    input  logic [7:0] alm_min,
    output logic       alarm
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
    localparam bit         H12      = (HOUR_MODE == 12);
    localparam logic [7:0] HR_RST   = H12 ? 8'h12 : 8'h00;
    localparam logic [7:0] HR_FLOOR = H12 ? 8'h01 : 8'h00;
    localparam logic [7:0] HR_TOP   = H12 ? 8'h12 : 8'h23;

    logic [7:0]    hr_q, hr_d, min_q, min_d, sec_q, sec_d;
    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d, done_q, done_d, err_q, err_d;
    logic          ld_ok, upd;
    logic [7:0]    hr_up, min_up, sec_up, hr_dn, min_dn, sec_dn;

    // Minutes/seconds digit pair: 00..59
    function automatic logic [7:0] ms_inc(input logic [7:0] v);
        if (v[3:0] != 4'd9)      return {v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] != 4'd5) return {v[7:4] + 4'd1, 4'd0};
        else                     return 8'h00;
    endfunction

    function automatic logic [7:0] ms_dec(input logic [7:0] v);
        if (v[3:0] != 4'd0)      return {v[7:4], v[3:0] - 4'd1};
        else if (v[7:4] != 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                     return 8'h59;
    endfunction

    // Hours wrap top->floor going up (23->00 or 12->01) and floor->top going down
    function automatic logic [7:0] hr_inc(input logic [7:0] v);
        if (v == HR_TOP)         return HR_FLOOR;
        else if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
        else                     return {v[7:4] + 4'd1, 4'd0};
    endfunction

    function automatic logic [7:0] hr_dec(input logic [7:0] v);
        if (v == HR_FLOOR)       return HR_TOP;
        else if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
        else                     return {v[7:4] - 4'd1, 4'd9};
    endfunction

    // Candidate next times for both directions, carries/borrows rippling upward
    always_comb begin
        sec_up = ms_inc(sec_q);
        min_up = (sec_q == 8'h59) ? ms_inc(min_q) : min_q;
        hr_up  = (sec_q == 8'h59 && min_q == 8'h59) ? hr_inc(hr_q) : hr_q;
        sec_dn = ms_dec(sec_q);
        min_dn = (sec_q == 8'h00) ? ms_dec(min_q) : min_q;
        hr_dn  = (sec_q == 8'h00 && min_q == 8'h00) ? hr_dec(hr_q) : hr_q;
    end

    // Load value check: BCD digits, mm/ss below 60, hours inside the selected range
    always_comb begin
        ld_ok = (ld_sec[3:0] <= 4'd9) && (ld_sec[7:4] <= 4'd5) &&
                (ld_min[3:0] <= 4'd9) && (ld_min[7:4] <= 4'd5) && (ld_hr[3:0] <= 4'd9);
        if (H12)
            ld_ok = ld_ok && ((ld_hr[7:4] == 4'd0 && ld_hr[3:0] != 4'd0) ||
                              (ld_hr[7:4] == 4'd1 && ld_hr[3:0] <= 4'd2));
        else
            ld_ok = ld_ok && ((ld_hr[7:4] <= 4'd1) ||
                              (ld_hr[7:4] == 4'd2 && ld_hr[3:0] <= 4'd3));
    end

    // Next state: load beats step; a rejected load freezes everything for that cycle
    always_comb begin
        hr_d   = hr_q;
        min_d  = min_q;
        sec_d  = sec_q;
        div_d  = div_q;
        done_d = done_q;
        tick_d = 1'b0;
        err_d  = 1'b0;
        upd    = 1'b0;
        if (load) begin
            if (ld_ok) begin
                hr_d   = ld_hr;
                min_d  = ld_min;
                sec_d  = ld_sec;
                div_d  = '0;
                done_d = 1'b0;
                upd    = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (run) begin
            if (div_q == DIV_MAX) begin
                div_d = '0;
                // Countdown parked on the floor: divider keeps running, time stays put
                if (!(done_q && dir)) begin
                    hr_d   = dir ? hr_dn  : hr_up;
                    min_d  = dir ? min_dn : min_up;
                    sec_d  = dir ? sec_dn : sec_up;
                    tick_d = 1'b1;
                    upd    = 1'b1;
                    if (dir && hr_d == HR_FLOOR && min_d == 8'h00 && sec_d == 8'h00)
                        done_d = 1'b1;
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    // State registers; every output comes straight from here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr_q   <= HR_RST;
            min_q  <= 8'h00;
            sec_q  <= 8'h00;
            div_q  <= '0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hr_q   <= hr_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign hr       = hr_q;
    assign min      = min_q;
    assign sec      = sec_q;
    assign tick     = tick_q;
    assign done     = done_q;
    assign load_err = err_q;

`ifdef RTC_ALARM_EN
    logic alarm_q, alarm_d;

    // Alarm sets when the new time lands on hh:mm:00; clear or disarm wins over set
    always_comb begin
        alarm_d = alarm_q;
        if (upd && alm_arm && hr_d == alm_hr && min_d == alm_min && sec_d == 8'h00)
            alarm_d = 1'b1;
        if (alm_clr || !alm_arm)
            alarm_d = 1'b0;
    end

    // Sticky alarm flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) alarm_q <= 1'b0;
        else     alarm_q <= alarm_d;
    end

    assign alarm = alarm_q;
`else
    logic unused_alm;
    assign unused_alm = ^{alm_arm, alm_clr, alm_hr, alm_min, upd};
    assign alarm      = 1'b0;
`endif
endmodule

// File: tb/tb_rtc_bcd_counter.sv
// Bench for rtc_bcd_counter: 24h and 12h instances share stimulus; a seconds-index
// reference model checks every cycle, plus a load table and hand-written sequences.
module tb_rtc_bcd_counter;
    localparam int DIV = 10;
`ifdef RTC_ALARM_EN
    localparam bit ALM_EN = 1'b1;
`else
    localparam bit ALM_EN = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1, run = 1'b0, dir = 1'b0, load = 1'b0;
    logic [7:0] ld_hr = 8'h00, ld_min = 8'h00, ld_sec = 8'h00;
    logic       alm_arm = 1'b0, alm_clr = 1'b0;
    logic [7:0] alm_hr = 8'h00, alm_min = 8'h00;
    logic [7:0] hr24, min24, sec24, hr12, min12, sec12;
    logic       tick24, done24, err24, alarm24, tick12, done12, err12, alarm12;
    int         checks = 0, errors = 0;

    rtc_bcd_counter #(.CLK_HZ(10), .TICK_HZ(1), .HOUR_MODE(24)) dut24 (
        .clk(clk), .rst(rst), .run(run), .dir(dir), .load(load),
        .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
        .hr(hr24), .min(min24), .sec(sec24), .tick(tick24), .done(done24), .load_err(err24),
        .alm_arm(alm_arm), .alm_clr(alm_clr), .alm_hr(alm_hr), .alm_min(alm_min), .alarm(alarm24));

    rtc_bcd_counter #(.CLK_HZ(10), .TICK_HZ(1), .HOUR_MODE(12)) dut12 (
        .clk(clk), .rst(rst), .run(run), .dir(dir), .load(load),
        .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
        .hr(hr12), .min(min12), .sec(sec12), .tick(tick12), .done(done12), .load_err(err12),
        .alm_arm(alm_arm), .alm_clr(alm_clr), .alm_hr(alm_hr), .alm_min(alm_min), .alarm(alarm12));

    always #5 clk = ~clk;

    // ---------------- reference model: time as seconds index ----------------
    // 24h: index = seconds since 00:00:00. 12h: index 0 is 12:00:00, so the
    // 12->01 rollover is plain arithmetic modulo 43200.
    typedef struct packed {
        int t;
        int dv;
        bit dn;
        bit tk;
        bit er;
        bit al;
    } mstate_t;

    mstate_t ms [2];

    function automatic int period(input int m);
        return (m != 0) ? 43200 : 86400;
    endfunction

    function automatic int floor_idx(input int m);
        return (m != 0) ? 3600 : 0;
    endfunction

    function automatic int bcd2int(input logic [7:0] b);
        return 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [23:0] disp(input int m, input int t);
        int h;
        h = t / 3600;
        if (m != 0 && h == 0) h = 12;
        return {int2bcd(h), int2bcd((t / 60) % 60), int2bcd(t % 60)};
    endfunction

    function automatic bit ld_valid(input int m, input logic [7:0] h, input logic [7:0] mi,
                                    input logic [7:0] s);
        int hv;
        if (h[3:0] > 4'd9 || mi[3:0] > 4'd9 || s[3:0] > 4'd9 || mi[7:4] > 4'd5 || s[7:4] > 4'd5)
            return 1'b0;
        hv = bcd2int(h);
        return (m != 0) ? (hv >= 1 && hv <= 12) : (hv <= 23);
    endfunction

    function automatic int load_idx(input int m, input logic [7:0] h, input logic [7:0] mi,
                                    input logic [7:0] s);
        int hv;
        hv = bcd2int(h);
        if (m != 0 && hv == 12) hv = 0;
        return hv * 3600 + bcd2int(mi) * 60 + bcd2int(s);
    endfunction

    function automatic mstate_t mnext(input int m, input mstate_t s);
        mstate_t     n;
        bit          upd;
        logic [23:0] d;
        n    = s;
        upd  = 1'b0;
        n.tk = 1'b0;
        n.er = 1'b0;
        if (load) begin
            if (ld_valid(m, ld_hr, ld_min, ld_sec)) begin
                n.t  = load_idx(m, ld_hr, ld_min, ld_sec);
                n.dv = 0;
                n.dn = 1'b0;
                upd  = 1'b1;
            end else begin
                n.er = 1'b1;
            end
        end else if (run) begin
            if (s.dv == DIV - 1) begin
                n.dv = 0;
                if (!(s.dn && dir)) begin
                    n.t  = dir ? (s.t + period(m) - 1) % period(m) : (s.t + 1) % period(m);
                    n.tk = 1'b1;
                    upd  = 1'b1;
                    if (dir && n.t == floor_idx(m)) n.dn = 1'b1;
                end
            end else begin
                n.dv = s.dv + 1;
            end
        end
        d = disp(m, n.t);
        if (ALM_EN && upd && alm_arm && d[23:16] == alm_hr && d[15:8] == alm_min && d[7:0] == 8'h00)
            n.al = 1'b1;
        if (ALM_EN && (alm_clr || !alm_arm))
            n.al = 1'b0;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ms[0] <= '0;
            ms[1] <= '0;
        end else begin
            ms[0] <= mnext(0, ms[0]);
            ms[1] <= mnext(1, ms[1]);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("model24", {hr24, min24, sec24, tick24, done24, err24, alarm24},
              {disp(0, ms[0].t), ms[0].tk, ms[0].dn, ms[0].er, ms[0].al});
        check("model12", {hr12, min12, sec12, tick12, done12, err12, alarm12},
              {disp(1, ms[1].t), ms[1].tk, ms[1].dn, ms[1].er, ms[1].al});
    endtask

    // One clock; outputs sampled 1 time unit after the active edge
    task automatic cyc();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        ld_hr  = h;
        ld_min = mi;
        ld_sec = s;
        load   = 1'b1;
        cyc();
        load   = 1'b0;
    endtask

    typedef struct {
        logic [7:0] h;
        logic [7:0] mi;
        logic [7:0] s;
        bit         ok24;
        bit         ok12;
    } vec_t;

    vec_t tbl [13];
    int   nt;

    initial begin
        tbl[0]  = '{8'h23, 8'h59, 8'h59, 1'b1, 1'b0};
        tbl[1]  = '{8'h12, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[2]  = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{8'h24, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{8'h13, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[5]  = '{8'h01, 8'h60, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{8'h01, 8'h00, 8'h5A, 1'b0, 1'b0};
        tbl[7]  = '{8'h09, 8'h59, 8'h59, 1'b1, 1'b1};
        tbl[8]  = '{8'h0A, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{8'h20, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[10] = '{8'h10, 8'h45, 8'h30, 1'b1, 1'b1};
        tbl[11] = '{8'h12, 8'h5F, 8'h00, 1'b0, 1'b0};
        tbl[12] = '{8'h01, 8'h00, 8'h00, 1'b1, 1'b1};

        // ---- reset state ----
        cyc();
        cyc();
        check("rst24", {hr24, min24, sec24, tick24, done24, err24, alarm24}, 32'h0);
        check("rst12", {hr12, min12, sec12, tick12, done12, err12, alarm12}, {8'h12, 16'h0, 4'h0});

        // ---- release with run=1: tick every DIV cycles ----
        rst = 1'b0;
        run = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            cyc();
            check("up_tick", {31'h0, tick24}, {31'h0, (i % 10 == 0)});
            if (i == 9)  check("sec_before_step", {24'h0, sec24}, 32'h00);
            if (i == 10) check("sec_first_step", {24'h0, sec24}, 32'h01);
        end
        check("sec_after_25", {24'h0, sec24}, 32'h02);

        // ---- asynchronous reset mid-count ----
        #3 rst = 1'b1;
        #1;
        check("async_rst24", {hr24, min24, sec24, tick24, done24, err24, alarm24}, 32'h0);
        check("async_rst12", {hr12, min12, sec12, tick12, done12, err12, alarm12}, {8'h12, 16'h0, 4'h0});
        cyc();
        rst = 1'b0;
        run = 1'b0;

        // ---- load validation table ----
        for (int k = 0; k < 13; k++) begin
            do_load(8'h05, 8'h06, 8'h07);
            do_load(tbl[k].h, tbl[k].mi, tbl[k].s);
            check("ld_err24", {31'h0, err24}, {31'h0, !tbl[k].ok24});
            check("ld_err12", {31'h0, err12}, {31'h0, !tbl[k].ok12});
            check("ld_val24", {8'h0, hr24, min24, sec24},
                  tbl[k].ok24 ? {8'h0, tbl[k].h, tbl[k].mi, tbl[k].s} : 32'h050607);
            check("ld_val12", {8'h0, hr12, min12, sec12},
                  tbl[k].ok12 ? {8'h0, tbl[k].h, tbl[k].mi, tbl[k].s} : 32'h050607);
        end

        // ---- 24h wrap ----
        do_load(8'h23, 8'h59, 8'h58);
        run = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == 9)  check("wrap24_a", {7'h0, hr24, min24, sec24, tick24}, {7'h0, 24'h235958, 1'b0});
            if (i == 10) check("wrap24_b", {7'h0, hr24, min24, sec24, tick24}, {7'h0, 24'h235959, 1'b1});
            if (i == 19) check("wrap24_c", {7'h0, hr24, min24, sec24, tick24}, {7'h0, 24'h235959, 1'b0});
            if (i == 20) check("wrap24_d", {7'h0, hr24, min24, sec24, tick24}, {7'h0, 24'h000000, 1'b1});
        end

        // ---- 12h wraps ----
        run = 1'b0;
        do_load(8'h11, 8'h59, 8'h59);
        run = 1'b1;
        repeat (10) cyc();
        check("wrap12_11", {7'h0, hr12, min12, sec12, tick12}, {7'h0, 24'h120000, 1'b1});
        check("wrap24_11", {8'h0, hr24, min24, sec24}, 32'h120000);
        run = 1'b0;
        do_load(8'h12, 8'h59, 8'h59);
        run = 1'b1;
        repeat (10) cyc();
        check("wrap12_12", {8'h0, hr12, min12, sec12}, 32'h010000);
        check("wrap24_12", {8'h0, hr24, min24, sec24}, 32'h130000);
        run = 1'b0;
        do_load(8'h00, 8'h00, 8'h00);
        check("hr00_err12", {31'h0, err12}, 32'h1);
        check("hr00_keep12", {8'h0, hr12, min12, sec12}, 32'h010000);
        check("hr00_ok24", {7'h0, hr24, min24, sec24, err24}, 32'h0);

        // ---- countdown to the floor ----
        do_load(8'h00, 8'h01, 8'h01);
        dir = 1'b1;
        run = 1'b1;
        nt  = 0;
        for (int i = 1; i <= 650; i++) begin
            cyc();
            if (tick24) nt++;
            if (i == 10)  check("dn_0100", {8'h0, hr24, min24, sec24}, 32'h000100);
            if (i == 20)  check("dn_0059", {8'h0, hr24, min24, sec24}, 32'h000059);
            if (i == 600) check("dn_0001", {7'h0, hr24, min24, sec24, done24}, {7'h0, 24'h000001, 1'b0});
            if (i == 610) check("dn_floor", {6'h0, hr24, min24, sec24, done24, tick24}, {6'h0, 24'h0, 2'b11});
        end
        check("dn_ticks", nt, 61);
        check("dn_hold", {7'h0, hr24, min24, sec24, done24}, {7'h0, 24'h0, 1'b1});
        dir = 1'b0;
        repeat (10) cyc();
        check("up_after_done", {6'h0, hr24, min24, sec24, tick24, done24}, {6'h0, 24'h000001, 2'b11});
        run = 1'b0;
        do_load(8'h00, 8'h00, 8'h05);
        check("load_clr_done", {31'h0, done24}, 32'h0);
        do_load(8'h01, 8'h00, 8'h02);
        dir = 1'b1;
        run = 1'b1;
        repeat (20) cyc();
        check("dn12_floor", {7'h0, hr12, min12, sec12, done12}, {7'h0, 24'h010000, 1'b1});
        check("dn24_nofloor", {7'h0, hr24, min24, sec24, done24}, {7'h0, 24'h010000, 1'b0});

        // ---- pause at div=4 ----
        run = 1'b0;
        dir = 1'b0;
        do_load(8'h10, 8'h00, 8'h00);
        run = 1'b1;
        repeat (4) cyc();
        run = 1'b0;
        nt  = 0;
        repeat (7) begin
            cyc();
            if (tick24) nt++;
        end
        check("pause_noticks", nt, 0);
        check("pause_hold", {8'h0, hr24, min24, sec24}, 32'h100000);
        run = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            check("resume_tick", {31'h0, tick24}, {31'h0, (i == 6)});
        end
        check("resume_val", {8'h0, hr24, min24, sec24}, 32'h100001);

        // ---- load colliding with a step ----
        run = 1'b0;
        do_load(8'h10, 8'h00, 8'h00);
        run = 1'b1;
        repeat (9) cyc();
        check("coll_pre", {31'h0, tick24}, 32'h0);
        do_load(8'h04, 8'h05, 8'h06);
        check("coll_load", {7'h0, hr24, min24, sec24, tick24}, {7'h0, 24'h040506, 1'b0});
        for (int i = 1; i <= 10; i++) begin
            cyc();
            check("coll_tick", {31'h0, tick24}, {31'h0, (i == 10)});
        end
        check("coll_next", {8'h0, hr24, min24, sec24}, 32'h040507);

        // ---- alarm ----
        run     = 1'b0;
        alm_hr  = 8'h07;
        alm_min = 8'h30;
        alm_arm = 1'b1;
        do_load(8'h07, 8'h29, 8'h59);
        check("alm_pre", {31'h0, alarm24}, 32'h0);
        run = 1'b1;
        repeat (10) cyc();
        check("alm_set24", {31'h0, alarm24}, {31'h0, ALM_EN});
        check("alm_set12", {31'h0, alarm12}, {31'h0, ALM_EN});
        alm_clr = 1'b1;
        cyc();
        alm_clr = 1'b0;
        check("alm_clr", {31'h0, alarm24}, 32'h0);

        // ---- randomized run against the model (checked every cycle in cyc) ----
        for (int i = 0; i < 3000; i++) begin
            run     = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) dir = ~dir;
            alm_arm = ($urandom_range(0, 19) != 0);
            alm_clr = ($urandom_range(0, 49) == 0);
            load    = ($urandom_range(0, 29) == 0);
            if (load) begin
                if ($urandom_range(0, 3) == 0) begin
                    ld_hr  = 8'($urandom);
                    ld_min = 8'($urandom);
                    ld_sec = 8'($urandom);
                end else begin
                    ld_hr  = int2bcd($urandom_range(0, 24));
                    ld_min = ($urandom_range(0, 2) == 0) ? 8'h59 : int2bcd($urandom_range(0, 59));
                    ld_sec = int2bcd($urandom_range(50, 59));
                    if ($urandom_range(0, 1) == 0) begin
                        alm_hr  = ld_hr;
                        alm_min = int2bcd((bcd2int(ld_min) + 1) % 60);
                    end
                end
            end
            cyc();
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
